// File: rtl/fifo_pdata_pack.sv
// fifo_pdata_pack: packs RATIO beats of DW bits (LSB-first) into DW*RATIO-bit words held in a 2**AW-word buffer.
// Latency: rd_data/rd_vld one cycle after an accepted rd_en (two cycles when FIFO_PDATA_PACK_OREG_EN is defined).
// Backpressure: none upstream; writes/flushes while full are dropped (sticky ovf), reads while empty set sticky udf.
// Ports: clk/rstn (async active-low); wr_en/wr_data beat in; flush pushes a zero-padded partial word;
//   rd_en pops; rd_data/rd_vld read result; empty/full/level word-count flags; pack_cnt beats in the packer;
//   ovf/udf sticky error flags.
// Build option: FIFO_PDATA_PACK_OREG_EN adds an output register after the RAM read.
module fifo_pdata_pack #(
  parameter int DW    = 8,
  parameter int RATIO = 4,
  parameter int AW    = 6
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       wr_en,
  input  logic [DW-1:0]              wr_data,
  input  logic                       flush,
  input  logic                       rd_en,
  output logic [DW*RATIO-1:0]        rd_data,
  output logic                       rd_vld,
  output logic                       empty,
  output logic                       full,
  output logic [AW:0]                level,
  output logic [$clog2(RATIO)-1:0]   pack_cnt,
  output logic                       ovf,
  output logic                       udf
);

  localparam int OW    = DW * RATIO;
  localparam int DEPTH = 2 ** AW;
  localparam int CW    = $clog2(RATIO);
  localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(RATIO - 1);

  logic [OW-1:0] mem [DEPTH];
  logic [OW-1:0] pack_buf;
  logic [OW-1:0] merged;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   level_nxt;
  logic [OW-1:0] ram_q;
  logic          ram_vld;
  logic          beat_acc;
  logic          word_done;
  logic          flush_acc;
  logic          push;
  logic          pop;

  // The packer buffer is cleared on every push, so unfilled lanes of a
  // flushed word are already zero; merged is the buffer with this cycle's
  // beat dropped into its lane, so a same-cycle beat+flush pushes it too.
  always_comb begin
    beat_acc  = wr_en & ~full;
    word_done = beat_acc & (pack_cnt == CNT_LAST);
    flush_acc = flush & ~full & ((pack_cnt != '0) | beat_acc);
    push      = word_done | flush_acc;
    pop       = rd_en & ~empty;
    merged    = pack_buf;
    if (beat_acc) merged[pack_cnt*DW +: DW] = wr_data;
  end

  always_comb begin
    level_nxt = level;
    case ({push, pop})
      2'b10:   level_nxt = level + LVL_ONE;
      2'b01:   level_nxt = level - LVL_ONE;
      default: level_nxt = level;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pack_buf <= '0;
      pack_cnt <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      empty    <= 1'b1;
      full     <= 1'b0;
      ovf      <= 1'b0;
      udf      <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr   <= wr_ptr + AW'(1);
        pack_buf <= '0;
        pack_cnt <= '0;
      end else if (beat_acc) begin
        pack_buf <= merged;
        pack_cnt <= pack_cnt + CW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      level <= level_nxt;
      empty <= (level_nxt == '0);
      full  <= (level_nxt == LVL_FULL);
      if ((wr_en | flush) & full) ovf <= 1'b1;
      if (rd_en & empty)          udf <= 1'b1;
    end
  end

  // Storage kept free of reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= merged;
  end

  // Registered read port; ram_q holds its value between pops.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ram_q   <= '0;
      ram_vld <= 1'b0;
    end else begin
      ram_vld <= pop;
      if (pop) ram_q <= mem[rd_ptr];
    end
  end

`ifdef FIFO_PDATA_PACK_OREG_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_data <= '0;
      rd_vld  <= 1'b0;
    end else begin
      rd_vld <= ram_vld;
      if (ram_vld) rd_data <= ram_q;
    end
  end
`else
  assign rd_data = ram_q;
  assign rd_vld  = ram_vld;
`endif

endmodule

// File: tb/tb_fifo_pdata_pack.sv
module tb_fifo_pdata_pack;
  localparam int DW    = 8;
  localparam int RATIO = 4;
  localparam int AW    = 6;
  localparam int OW    = DW * RATIO;
  localparam int DEPTH = 2 ** AW;
`ifdef FIFO_PDATA_PACK_OREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic          clk = 1'b0;
  logic          rstn;
  logic          wr_en, flush, rd_en;
  logic [DW-1:0] wr_data;
  logic [OW-1:0] rd_data;
  logic          rd_vld, empty, full, ovf, udf;
  logic [AW:0]   level;
  logic [1:0]    pack_cnt;

  fifo_pdata_pack #(.DW(DW), .RATIO(RATIO), .AW(AW)) dut (
    .clk(clk), .rstn(rstn), .wr_en(wr_en), .wr_data(wr_data), .flush(flush),
    .rd_en(rd_en), .rd_data(rd_data), .rd_vld(rd_vld), .empty(empty),
    .full(full), .level(level), .pack_cnt(pack_cnt), .ovf(ovf), .udf(udf)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: stored words, beats waiting in the packer, sticky flags,
  // and a delay line of popped words to account for read latency.
  logic [OW-1:0] mq[$];
  logic [DW-1:0] pk[$];
  bit            m_ovf, m_udf;
  bit            pv [1:2];
  logic [OW-1:0] pd [1:2];
  logic [OW-1:0] last_d;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [OW-1:0] packw();
    logic [OW-1:0] w = '0;
    foreach (pk[i]) w |= OW'(pk[i]) << (DW * i);
    return w;
  endfunction

  task automatic model_reset();
    mq.delete(); pk.delete();
    m_ovf = 0; m_udf = 0;
    pv[1] = 0; pv[2] = 0; pd[1] = '0; pd[2] = '0;
    last_d = '0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_rd_data"}, rd_data, 0);
    chk({tag, "_rd_vld"}, rd_vld, 0);
    chk({tag, "_empty"}, empty, 1);
    chk({tag, "_full"}, full, 0);
    chk({tag, "_level"}, level, 0);
    chk({tag, "_pack_cnt"}, pack_cnt, 0);
    chk({tag, "_ovf"}, ovf, 0);
    chk({tag, "_udf"}, udf, 0);
  endtask

  // One clock cycle: drive inputs, advance the model, then compare every output.
  task automatic step(input bit we, input logic [DW-1:0] wd, input bit fl, input bit re);
    bit            full_m, empty_m, popv;
    logic [OW-1:0] popd;
    logic [OW-1:0] exp_d;
    wr_en = we; wr_data = wd; flush = fl; rd_en = re;
    full_m  = (mq.size() == DEPTH);
    empty_m = (mq.size() == 0);
    popv = 0; popd = '0;
    if (re) begin
      if (!empty_m) begin popd = mq.pop_front(); popv = 1; end
      else m_udf = 1;
    end
    if (we) begin
      if (full_m) m_ovf = 1;
      else begin
        pk.push_back(wd);
        if (pk.size() == RATIO) begin mq.push_back(packw()); pk.delete(); end
      end
    end
    if (fl) begin
      if (full_m) m_ovf = 1;
      else if (pk.size() != 0) begin mq.push_back(packw()); pk.delete(); end
    end
    @(posedge clk); #1;
    pv[2] = pv[1]; pd[2] = pd[1];
    pv[1] = popv;  pd[1] = popd;
    exp_d = pv[LAT] ? pd[LAT] : last_d;
    last_d = exp_d;
    chk("rd_vld", rd_vld, pv[LAT]);
    chk("rd_data", rd_data, exp_d);
    chk("level", level, mq.size());
    chk("empty", empty, mq.size() == 0);
    chk("full", full, mq.size() == DEPTH);
    chk("pack_cnt", pack_cnt, pk.size());
    chk("ovf", ovf, m_ovf);
    chk("udf", udf, m_udf);
    wr_en = 0; flush = 0; rd_en = 0;
  endtask

  task automatic idle(); step(0, '0, 0, 0); endtask

  task automatic read_expect(input string tag, input logic [OW-1:0] exp);
    step(0, '0, 0, 1);
    if (LAT == 2) idle();
    chk({tag, "_vld"}, rd_vld, 1);
    chk({tag, "_word"}, rd_data, exp);
  endtask

  task automatic do_reset();
    rstn = 0;
    model_reset();
    #1;
    chk_reset("rst");
    @(negedge clk); @(negedge clk);
    rstn = 1;
  endtask

  initial begin
    int nb;
    rstn = 0; wr_en = 0; wr_data = '0; flush = 0; rd_en = 0;
    model_reset();
    @(negedge clk);
    do_reset();

    // 1: four beats form one word, read back LSB-first
    step(1, 8'h11, 0, 0); step(1, 8'h22, 0, 0);
    step(1, 8'h33, 0, 0); step(1, 8'h44, 0, 0);
    chk("t1_level1", level, 1);
    read_expect("t1", 32'h44332211);
    chk("t1_level0", level, 0);
    idle();
    chk("t1_vld_pulse", rd_vld, 0);

    // 2: fill to full, overflow, then drain in order
    for (int i = 0; i < 4 * DEPTH; i++) step(1, DW'($urandom), 0, 0);
    chk("t2_full", full, 1);
    chk("t2_level", level, DEPTH);
    step(1, 8'h5A, 0, 0);
    chk("t2_ovf", ovf, 1);
    chk("t2_pack_cnt", pack_cnt, 0);
    for (int i = 0; i < DEPTH; i++) step(0, '0, 0, 1);
    for (int i = 0; i < LAT; i++) idle();
    chk("t2_empty", empty, 1);

    // 3: partial flush, and beat+flush in one cycle
    step(1, 8'hAA, 0, 0); step(1, 8'hBB, 0, 0);
    step(0, '0, 1, 0);
    chk("t3_pack_cnt", pack_cnt, 0);
    read_expect("t3a", 32'h0000BBAA);
    step(1, 8'hCC, 1, 0);
    chk("t3_cc_level", level, 1);
    read_expect("t3b", 32'h000000CC);
    step(0, '0, 1, 0);
    chk("t3_noop_flush", level, 0);

    // 4: underflow after reset; push+pop at level 3
    do_reset();
    step(0, '0, 0, 1);
    chk("t4_udf", udf, 1);
    chk("t4_no_vld", rd_vld, 0);
    for (int i = 0; i < 4 * 3 + 3; i++) step(1, DW'($urandom), 0, 0);
    chk("t4_level3", level, 3);
    step(1, DW'($urandom), 0, 1);
    chk("t4_level_hold", level, 3);
    for (int i = 0; i < LAT; i++) idle();

    // 5: random streaming of 200 words through the wrapping pointers
    do_reset();
    nb = 0;
    for (int c = 0; c < 6000 && (nb < 4 * 200 || mq.size() != 0); c++) begin
      bit we, re;
      we = (nb < 4 * 200) && (mq.size() < DEPTH) && ($urandom_range(0, 1) == 1);
      re = (mq.size() != 0) && ($urandom_range(0, 2) != 0);
      step(we, DW'($urandom), 0, re);
      if (we) nb++;
    end
    for (int i = 0; i < LAT; i++) idle();
    chk("t5_beats", nb, 4 * 200);
    chk("t5_drained", level, 0);
    chk("t5_ovf", ovf, 0);
    chk("t5_udf", udf, 0);

    // 6: asynchronous reset mid-stream with level=10, pack_cnt=2
    for (int i = 0; i < 4 * 10 + 2; i++) step(1, DW'($urandom), 0, 0);
    chk("t6_level", level, 10);
    chk("t6_pack_cnt", pack_cnt, 2);
    #3;
    do_reset();
    step(0, '0, 0, 1);
    for (int i = 0; i < LAT; i++) idle();
    chk("t6_no_stale", rd_vld, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
